// File: rtl/sr_arb_pkg.sv
// Shared definitions for the SR latch bank arbiter.
//   state_t : sequencer states (IDLE -> DRIVE -> RELEASE -> IDLE)
//   cnt_w() : settle counter width for a given SETTLE_CYC,
//             i.e. $clog2(SETTLE_CYC+1)
package sr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   function automatic int cnt_w(input int settle_cyc);
      return $clog2(settle_cyc + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick.
// Rotates req so that rr_ptr sits at bit 0, takes the lowest set bit,
// then rotates the one-hot result back into requester numbering.
//   req    in  NREQ  request vector
//   rr_ptr in  PW    highest-priority requester index (0..NREQ-1)
//   win    out NREQ  one-hot winner, all zero when req is zero
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   rr_ptr,
   output logic [NREQ-1:0] win
);

   logic [2*NREQ-1:0] req_dbl;
   logic [2*NREQ-1:0] pe_dbl;
   logic [NREQ-1:0]   rot;
   logic [NREQ-1:0]   pe;
   logic [PW:0]       back;
   logic              found;

   always_comb begin
      // doubled vector turns the rotate into a plain part-select
      req_dbl = {req, req};
      rot     = req_dbl[rr_ptr +: NREQ];

      pe    = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (rot[k] && !found) begin
            pe[k] = 1'b1;
            found = 1'b1;
         end
      end

      // rotate back by NREQ - rr_ptr (NREQ when rr_ptr = 0 is the identity)
      pe_dbl = {pe, pe};
      back   = (PW+1)'(NREQ) - {1'b0, rr_ptr};
      win    = pe_dbl[back +: NREQ];
   end

endmodule

// File: rtl/sr_latch_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit bank of gated SR
// latches among NREQ requesters. The winner's masks are captured at grant,
// driven with lat_en high for SETTLE_CYC cycles, then lat_en and the s/r
// lines drop together while done pulses, so s/r never move while the gate
// is open. All outputs are registered.
//
// Optional feature macro: SRARB_CONFLICT_CHECK_EN
//   defined     : a captured mask with set&rst != 0 skips DRIVE and pulses
//                 err together with done; adds the err port.
//   not defined : conflicting bits resolve as reset-wins; no err port.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous reset, active-low
//   req     in   NREQ        level request, held until done
//   op_set  in   NREQ*WIDTH  set mask, slice i = [i*WIDTH +: WIDTH]
//   op_rst  in   NREQ*WIDTH  reset mask, same slicing
//   gnt     out  NREQ        one-hot grant
//   done    out  NREQ        one-cycle completion pulse to the winner
//   lat_s   out  WIDTH       set lines to the latch bank
//   lat_r   out  WIDTH       reset lines to the latch bank
//   lat_en  out  1           latch gate enable
//   busy    out  1           high in any state but IDLE
//   err     out  1           conflict pulse (SRARB_CONFLICT_CHECK_EN only)
module sr_latch_bank_arbiter
   import sr_arb_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int WIDTH      = 8,
   parameter int SETTLE_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] op_set,
   input  logic [NREQ*WIDTH-1:0] op_rst,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic [WIDTH-1:0]      lat_s,
   output logic [WIDTH-1:0]      lat_r,
   output logic                  lat_en,
   output logic                  busy
`ifdef SRARB_CONFLICT_CHECK_EN
   ,
   output logic                  err
`endif
);

   localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = cnt_w(SETTLE_CYC);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [PW-1:0]    rr_ptr;
   logic [NREQ-1:0]  win;
   logic [WIDTH-1:0] sel_set;
   logic [WIDTH-1:0] sel_rst;
   logic [PW-1:0]    nxt_ptr;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .win    (win)
   );

   // winner's masks and the pointer that follows it
   always_comb begin
      sel_set = '0;
      sel_rst = '0;
      nxt_ptr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win[i]) begin
            sel_set = op_set[i*WIDTH +: WIDTH];
            sel_rst = op_rst[i*WIDTH +: WIDTH];
            nxt_ptr = (i == NREQ-1) ? '0 : PW'(i + 1);
         end
      end
   end

   // lat_s/lat_r double as the capture registers: they are loaded once at
   // grant and held untouched until release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         rr_ptr <= '0;
         gnt    <= '0;
         done   <= '0;
         lat_s  <= '0;
         lat_r  <= '0;
         lat_en <= 1'b0;
         busy   <= 1'b0;
`ifdef SRARB_CONFLICT_CHECK_EN
         err    <= 1'b0;
`endif
      end else begin
         done <= '0;
`ifdef SRARB_CONFLICT_CHECK_EN
         err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (|req) begin
                  rr_ptr <= nxt_ptr;
                  busy   <= 1'b1;
`ifdef SRARB_CONFLICT_CHECK_EN
                  if (|(sel_set & sel_rst)) begin
                     // never open the gate on a forbidden input
                     done  <= win;
                     err   <= 1'b1;
                     state <= RELEASE;
                  end else
`endif
                  begin
                     gnt    <= win;
                     lat_en <= 1'b1;
                     // reset wins on any bit with both set and reset
                     lat_s  <= sel_set & ~sel_rst;
                     lat_r  <= sel_rst;
                     cnt    <= CNT_W'(SETTLE_CYC - 1);
                     state  <= DRIVE;
                  end
               end
            end
            DRIVE: begin
               if (cnt == '0) begin
                  lat_en <= 1'b0;
                  lat_s  <= '0;
                  lat_r  <= '0;
                  gnt    <= '0;
                  done   <= gnt;
                  state  <= RELEASE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RELEASE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
